multdiv_ctrl: RTL and testbench

- Sequencing controller for the HI/LO multiply/divide resource in the execute stage.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per instruction and owns the HI/LO architectural registers.
- Multiplies run through a MUL_LAT-stage product path; divides through an iterative radix-2 sub-unit.
- Holds the pipeline via stall_o until the result is committed, and aborts cleanly on flush.

---
 rtl/multdiv_pkg.sv | 33 +++
 rtl/multdiv_ctrl_div.sv | 99 +++++++++
 rtl/multdiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
// Contents: md_op_t operation encoding, md_state_t controller states,
// MD_DIV0_QUOT divide-by-zero quotient, is_md_long() helper.
package multdiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    localparam logic [31:0] MD_DIV0_QUOT = 32'hFFFF_FFFF;

    // Multi-cycle ops that stall the pipeline.
    function automatic logic is_md_long(input md_op_t op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multdiv_ctrl_div.sv
// div_radix2: iterative restoring radix-2 divider, one quotient bit per cycle.
// Ports:
//   clk, resetn      clock, async active-low reset
//   start            load operands (first iteration is done on the load edge)
//   abort            drop the operation in flight, no done pulse
//   signed_en        treat a/b as two's complement
//   a, b             dividend, divisor
//   done             one-cycle pulse, quot/rem valid while high
//   quot, rem        final sign-corrected quotient and remainder
// Divide by zero returns quot=all-ones, rem=original dividend.
module div_radix2
    import multdiv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic        signed_en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic [31:0] rem_q, quot_q, dvs_q, a_q;
    logic        qneg_q, rneg_q, div0_q, run_q, done_q;
    logic [5:0]  cnt_q;

    logic [31:0] a_mag, b_mag;
    logic [63:0] first_step, next_step;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. quot register doubles
    // as the dividend shift register.
    function automatic logic [63:0] div_step(input logic [31:0] r,
                                             input logic [31:0] q,
                                             input logic [31:0] d);
        logic [32:0] sh, diff;
        logic [63:0] res;
        sh   = {r, q[31]};
        diff = sh - {1'b0, d};
        if (!diff[32]) res = {diff[31:0], q[30:0], 1'b1};
        else           res = {sh[31:0],   q[30:0], 1'b0};
        return res;
    endfunction

    assign a_mag      = (signed_en && a[31]) ? -a : a;
    assign b_mag      = (signed_en && b[31]) ? -b : b;
    assign first_step = div_step(32'd0, a_mag, b_mag);
    assign next_step  = div_step(rem_q, quot_q, dvs_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            a_q    <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            div0_q <= 1'b0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else if (abort) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            {rem_q, quot_q} <= first_step;
            dvs_q  <= b_mag;
            a_q    <= a;
            qneg_q <= signed_en && (a[31] ^ b[31]);
            rneg_q <= signed_en && a[31];
            div0_q <= (b == 32'd0);
            cnt_q  <= 6'(DIV_CYCLES - 1);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (run_q) begin
                {rem_q, quot_q} <= next_step;
                cnt_q <= cnt_q - 6'd1;
                // Last iteration: result is final after this edge.
                if (cnt_q == 6'd1) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign quot = div0_q ? MD_DIV0_QUOT : (qneg_q ? -quot_q : quot_q);
    assign rem  = div0_q ? a_q          : (rneg_q ? -rem_q  : rem_q);

endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: HI/LO multiply/divide sequencer for the execute stage.
// Owns HI/LO, runs multiplies through a MUL_LAT-cycle product path and
// divides through div_radix2, stalling the pipeline until commit.
// Ports:
//   clk, resetn       clock, async active-low reset
//   start_i, op_i     HI/LO op valid in execute and its md_op_t
//   a_i, b_i          rs / rt operands
//   flush_i           kill execute instruction, abort anything in flight
//   stall_o           hold fetch/decode/execute (combinational)
//   busy_o            controller not idle
//   hi_o, lo_o        HI / LO registers
// Build option: MULTDIV_DIV0_FAST_EN -- divide by zero commits one cycle
// after accept instead of running the full divider.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MUL_LAT    = 3,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  md_op_t      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    md_state_t   state_q;
    logic [2:0]  cnt_q;
    logic [31:0] ma_q, mb_q, hi_q, lo_q;
    logic        msigned_q;

    logic        accept, is_div_op;
    logic        div_start, div_abort, div_done, div_done_eff;
    logic [31:0] div_quot, div_rem, div_lo, div_hi;
    logic [63:0] ma_x, mb_x, prod;

    assign accept    = (state_q == ST_IDLE) && start_i && !flush_i;
    assign is_div_op = (op_i == MD_DIV) || (op_i == MD_DIVU);
    assign div_abort = flush_i && (state_q == ST_DIV);

    // Sign/zero extension to 64 bits gives the same low 64 bits as the
    // 33x33 product.
    assign ma_x = {{32{msigned_q & ma_q[31]}}, ma_q};
    assign mb_x = {{32{msigned_q & mb_q[31]}}, mb_q};
    assign prod = ma_x * mb_x;

`ifdef MULTDIV_DIV0_FAST_EN
    // Divide by zero bypasses the divider; result formed from the latched
    // dividend on the single DIV-state cycle.
    logic        div0_fast_q;
    logic [31:0] div0_a_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div0_fast_q <= 1'b0;
            div0_a_q    <= '0;
        end else if (accept && is_div_op) begin
            div0_fast_q <= (b_i == 32'd0);
            div0_a_q    <= a_i;
        end
    end

    assign div_start    = accept && is_div_op && (b_i != 32'd0);
    assign div_done_eff = div_done || div0_fast_q;
    assign div_lo       = div0_fast_q ? MD_DIV0_QUOT : div_quot;
    assign div_hi       = div0_fast_q ? div0_a_q     : div_rem;
`else
    assign div_start    = accept && is_div_op;
    assign div_done_eff = div_done;
    assign div_lo       = div_quot;
    assign div_hi       = div_rem;
`endif

    div_radix2 #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .abort     (div_abort),
        .signed_en (op_i == MD_DIV),
        .a         (a_i),
        .b         (b_i),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            msigned_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !flush_i) begin
                        case (op_i)
                            MD_MULT, MD_MULTU: begin
                                ma_q      <= a_i;
                                mb_q      <= b_i;
                                msigned_q <= (op_i == MD_MULT);
                                cnt_q     <= 3'(MUL_LAT - 1);
                                state_q   <= ST_MUL;
                            end
                            MD_DIV, MD_DIVU: state_q <= ST_DIV;
                            MD_MTHI:         hi_q    <= a_i;
                            MD_MTLO:         lo_q    <= a_i;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 3'd0) begin
                        {hi_q, lo_q} <= prod;
                        state_q      <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_DIV: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else if (div_done_eff) begin
                        lo_q    <= div_lo;
                        hi_q    <= div_hi;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stall drops in the commit cycle so the next instruction sees HI/LO.
    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            ST_IDLE: stall_o = start_i && !flush_i && is_md_long(op_i);
            ST_MUL:  stall_o = (cnt_q != 3'd0) && !flush_i;
            ST_DIV:  stall_o = !div_done_eff && !flush_i;
            default: stall_o = 1'b0;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl (MUL_LAT=3, DIV_CYCLES=32).
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    logic        clk, resetn, start_i, flush_i;
    md_op_t      op_i;
    logic [31:0] a_i, b_i, hi_o, lo_o;
    logic        stall_o, busy_o;

    int checks = 0;
    int failures = 0;

    multdiv_ctrl #(.MUL_LAT(3), .DIV_CYCLES(32)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULTDIV_DIV0_FAST_EN
    localparam int DIV0_STALL = 1;
`else
    localparam int DIV0_STALL = 32;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one op from just after a rising edge; count stalled cycles and
    // return just after the edge on which the instruction leaves execute.
    task automatic run_op(input md_op_t op, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        bit fin;
        fin = 1'b0;
        n = 0;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        for (int k = 0; k < 100 && !fin; k++) begin
            #1;
            if (!stall_o) fin = 1'b1;
            else n++;
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        if (!fin) chk("op_timeout", 32'd0, 32'd1);
    endtask

    int n;

    initial begin
        resetn = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        op_i = MD_MULT; a_i = '0; b_i = '0;
        #12;
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // MULT -2 * 3 = -6
        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, n);
        chk("mult_stall", n, 32'd3);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFFA);
        chk("mult_busy", {31'd0, busy_o}, 32'd0);

        // MTHI then back-to-back MULTU 2^16 * 2^16
        run_op(MD_MTHI, 32'h1234_5678, 32'd0, n);
        chk("mthi_stall", n, 32'd0);
        chk("mthi_hi", hi_o, 32'h1234_5678);
        run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, n);
        chk("multu_hi", hi_o, 32'd1);
        chk("multu_lo", lo_o, 32'd0);

        // MULTU of all-ones: no sign extension
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("multu_max_hi", hi_o, 32'hFFFF_FFFE);
        chk("multu_max_lo", lo_o, 32'd1);

        run_op(MD_DIVU, 32'd100, 32'd7, n);
        chk("divu_stall", n, 32'd32);
        chk("divu_lo", lo_o, 32'd14);
        chk("divu_hi", hi_o, 32'd2);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);

        run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, n);
        chk("div_negb_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_negb_hi", hi_o, 32'd1);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("div_ovf_lo", lo_o, 32'h8000_0000);
        chk("div_ovf_hi", hi_o, 32'd0);

        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd16, n);
        chk("divu_big_lo", lo_o, 32'h0FFF_FFFF);
        chk("divu_big_hi", hi_o, 32'd15);

        run_op(MD_DIV, 32'd5, 32'd0, n);
        chk("div0_stall", n, DIV0_STALL);
        chk("div0_lo", lo_o, 32'hFFFF_FFFF);
        chk("div0_hi", hi_o, 32'd5);

        run_op(MD_DIV, 32'hFFFF_FFFB, 32'd0, n);
        chk("div0_neg_lo", lo_o, 32'hFFFF_FFFF);
        chk("div0_neg_hi", hi_o, 32'hFFFF_FFFB);

        // Set known HI/LO, then flush a DIVU at iteration 10
        run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, n);
        start_i = 1'b1; op_i = MD_DIVU; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; start_i = 1'b0;
        #1;
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_hi", hi_o, 32'd1);
        chk("flush_lo", lo_o, 32'd0);
        chk("flush_stall_after", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        run_op(MD_MULT, 32'd7, 32'hFFFF_FFFE, n);
        chk("post_flush_stall", n, 32'd3);
        chk("post_flush_hi", hi_o, 32'hFFFF_FFFF);
        chk("post_flush_lo", lo_o, 32'hFFFF_FFF2);
        repeat (40) @(posedge clk);
        #1;
        chk("no_stray_lo", lo_o, 32'hFFFF_FFF2);

        // Flush landing on the multiply commit cycle: no write
        start_i = 1'b1; op_i = MD_MULT; a_i = 32'd2; b_i = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        chk("fcommit_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; start_i = 1'b0;
        chk("fcommit_hi", hi_o, 32'hFFFF_FFFF);
        chk("fcommit_lo", lo_o, 32'hFFFF_FFF2);
        chk("fcommit_busy", {31'd0, busy_o}, 32'd0);

        // Flushed MTHI in IDLE: no write
        start_i = 1'b1; op_i = MD_MTHI; a_i = 32'hDEAD_BEEF; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_mthi_hi", hi_o, 32'hFFFF_FFFF);

        run_op(MD_MTLO, 32'hCAFE_0001, 32'd0, n);
        chk("mtlo_lo", lo_o, 32'hCAFE_0001);
        chk("mtlo_hi", hi_o, 32'hFFFF_FFFF);

        // Reset during divide iteration 20
        start_i = 1'b1; op_i = MD_DIVU; a_i = 32'd99; b_i = 32'd4;
        @(posedge clk); #1;
        repeat (19) @(posedge clk);
        #2;
        start_i = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_mid_hi", hi_o, 32'd0);
        chk("rst_mid_lo", lo_o, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_post_hi", hi_o, 32'd0);
        chk("rst_post_lo", lo_o, 32'd0);
        chk("rst_post_busy", {31'd0, busy_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
